// File: rtl/roba_k_precompute_sched_pkg.sv
// Shared constants and helpers for the RoBA K pre-computation scheduler.
// Both derived widths go through clog2_min1 so a degenerate parameter never yields a zero-width bus.
package roba_pkg;

    localparam int B_BW_DEF    = 8;
    localparam int NUM_REQ_DEF = 4;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/roba_k_precompute_sched_if.sv
// Requester/result bundle for the K scheduler.
// master = requesters plus downstream shifter; slave = the scheduler itself.
interface roba_k_precompute_sched_if
    import roba_pkg::*;
#(
    parameter int B_BW    = B_BW_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
);
    localparam int K_W  = clog2_min1(B_BW);
    localparam int ID_W = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*B_BW-1:0] req_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [K_W-1:0]          out_k;
    logic                    out_zero;
    logic [B_BW-1:0]         out_b;
    logic [ID_W-1:0]         out_id;
    logic                    busy;

    modport master (
        output req_valid, req_b, out_ready,
        input  req_ready, out_valid, out_k, out_zero, out_b, out_id, busy
    );

    modport slave (
        input  req_valid, req_b, out_ready,
        output req_ready, out_valid, out_k, out_zero, out_b, out_id, busy
    );

endinterface

// File: rtl/roba_k_precompute_sched_lod.sv
// Leading-one detector and encoder: index of the most significant set bit of B.
// An all-zero operand reports index 0 with zero_o raised.
module roba_lod_encode
    import roba_pkg::*;
#(
    parameter  int B_BW = B_BW_DEF,
    localparam int K_W  = clog2_min1(B_BW)
) (
    input  logic [B_BW-1:0] b_i,
    output logic [K_W-1:0]  k_o,
    output logic            zero_o
);

    // NOTE: every output of a combinational block gets a default first; a path that skips an assignment infers a latch.
    always_comb begin
        k_o    = '0;
        zero_o = 1'b1;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < B_BW; i++) begin
            if (b_i[i]) begin
                k_o    = K_W'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/roba_k_precompute_sched.sv
// Round-robin shared LOD scheduler: arbitrate -> S1 (B, id) -> LOD/encode -> S2 (k, zero, b, id).
// Two-deep pipeline with full-throughput stall chain; accept at cycle N gives out_valid at N+2.
module roba_k_precompute_sched
    import roba_pkg::*;
#(
    parameter  int B_BW    = B_BW_DEF,
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int K_W     = clog2_min1(B_BW),
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input logic                       clk,
    input logic                       rst_n,
    roba_k_precompute_sched_if.slave  bus
);

    logic                s1_valid_q, s1_valid_d;
    logic [B_BW-1:0]     s1_b_q, s1_b_d;
    logic [ID_W-1:0]     s1_id_q, s1_id_d;

    logic                out_valid_q, out_valid_d;
    logic [K_W-1:0]      out_k_q, out_k_d;
    logic                out_zero_q, out_zero_d;
    logic [B_BW-1:0]     out_b_q, out_b_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;

    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic                s2_adv;
    logic                s1_adv;
    logic                accept_en;
    logic                take;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     grant_id;
    logic [NUM_REQ-1:0]  grant;
    logic [B_BW-1:0]     grant_b;

    logic [K_W-1:0]      lod_k;
    logic                lod_zero;

    assign s2_adv    = !out_valid_q || bus.out_ready;
    assign s1_adv    = s1_valid_q && s2_adv;
    // Gating with rst_n keeps req_ready at zero while reset is held, even with requesters valid.
    assign accept_en = rst_n && (!s1_valid_q || s1_adv);

    // First valid requester at or after the pointer, wrapping upward.
    always_comb begin
        take     = 1'b0;
        cand     = '0;
        grant_id = '0;
        grant    = '0;
        grant_b  = '0;
        if (accept_en) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
                if (!take && bus.req_valid[cand]) begin
                    take     = 1'b1;
                    grant_id = cand;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take && grant_id == ID_W'(i)) begin
                grant[i] = 1'b1;
                grant_b  = bus.req_b[i*B_BW +: B_BW];
            end
        end
    end

    roba_lod_encode #(
        .B_BW   (B_BW)
    ) u_lod (
        .b_i    (s1_b_q),
        .k_o    (lod_k),
        .zero_o (lod_zero)
    );

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        out_valid_d = out_valid_q;
        out_k_d     = out_k_q;
        out_zero_d  = out_zero_q;
        out_b_d     = out_b_q;
        out_id_d    = out_id_q;

        if (take) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end

        // S1 either empties or refills whenever it is allowed to accept.
        if (accept_en) begin
            s1_valid_d = take;
            if (take) begin
                s1_b_d  = grant_b;
                s1_id_d = grant_id;
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_k_d    = lod_k;
                out_zero_d = lod_zero;
                out_b_d    = s1_b_q;
                out_id_d   = s1_id_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too, because the out_* ports have defined reset values.
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_k_q     <= '0;
            out_zero_q  <= 1'b0;
            out_b_q     <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_k_q     <= out_k_d;
            out_zero_q  <= out_zero_d;
            out_b_q     <= out_b_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_k     = out_k_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_roba_k_precompute_sched.sv
// Directed bench for roba_k_precompute_sched: a capacity-2 queue model checked every cycle,
// plus literal expectations for each scenario that pin the model down.
module tb_roba_k_precompute_sched;

    localparam int B_BW    = 8;
    localparam int NUM_REQ = 4;

    typedef struct {
        logic [7:0] b;
        int         id;
        int         t;   // first cycle the item may be visible on the outputs
    } item_t;

    logic clk;
    logic rst_n;

    int    checks;
    int    errors;
    int    cyc;
    int    ptr_m;
    int    exp_gnt;
    logic  exp_ov;
    logic [7:0] exp_gb;
    item_t q[$];

    roba_k_precompute_sched_if #(.B_BW(B_BW), .NUM_REQ(NUM_REQ)) bus ();

    roba_k_precompute_sched #(
        .B_BW    (B_BW),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor(log2(b)) for b>0, expressed arithmetically.
    function automatic logic [31:0] ref_k(input logic [7:0] b);
        if (b == 8'h00) return 32'd0;
        return 32'($clog2(int'(b) + 1) - 1);
    endfunction

    // Model expectations for the current cycle, compared at the falling edge.
    task automatic compare();
        logic [31:0] exp_ready;
        exp_gnt = -1;
        exp_ov  = 1'b0;
        exp_gb  = '0;
        if (!rst_n) return;
        // Two results fit in flight; a third is admitted only while the oldest is leaving.
        if (q.size() < 2 || bus.out_ready) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                int i;
                i = (ptr_m + off) % NUM_REQ;
                if (exp_gnt < 0 && ((32'(bus.req_valid) >> i) & 32'd1) == 32'd1) exp_gnt = i;
            end
        end
        exp_ready = (exp_gnt >= 0) ? (32'd1 << exp_gnt) : 32'd0;
        if (exp_gnt >= 0) exp_gb = bus.req_b[exp_gnt*8 +: 8];
        exp_ov = (q.size() > 0) && (q[0].t <= cyc);
        check("m_req_ready", 32'(bus.req_ready), exp_ready);
        check("m_out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check("m_busy", 32'(bus.busy), 32'(q.size() > 0));
        if (exp_ov) begin
            check("m_out_id", 32'(bus.out_id), 32'(q[0].id));
            check("m_out_b", 32'(bus.out_b), 32'(q[0].b));
            check("m_out_k", 32'(bus.out_k), ref_k(q[0].b));
            check("m_out_zero", 32'(bus.out_zero), 32'(q[0].b == 8'h00));
        end
    endtask

    task automatic update();
        item_t it;
        if (!rst_n) begin
            q.delete();
            ptr_m = 0;
            return;
        end
        if (exp_ov && bus.out_ready) void'(q.pop_front());
        if (exp_gnt >= 0) begin
            it.b  = exp_gb;
            it.id = exp_gnt;
            it.t  = cyc + 2;
            q.push_back(it);
            ptr_m = (exp_gnt + 1) % NUM_REQ;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_k", 32'(bus.out_k), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        check("rst_out_b", 32'(bus.out_b), 32'd0);
        check("rst_out_id", 32'(bus.out_id), 32'd0);
        bus.req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int nacc;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        ptr_m         = 0;
        exp_gnt       = -1;
        exp_ov        = 1'b0;
        exp_gb        = '0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_b     = '0;
        bus.out_ready = 1'b0;
        #2;

        // 1: single transfer, two-cycle latency
        do_reset();
        bus.out_ready    = 1'b1;
        bus.req_b[7:0]   = 8'h16;
        bus.req_valid    = 4'b0001;
        #1 check("t1_grant", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 4'b0000;
        check("t1_not_yet", 32'(bus.out_valid), 32'd0);
        step();
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_k", 32'(bus.out_k), 32'd4);
        check("t1_zero", 32'(bus.out_zero), 32'd0);
        check("t1_b", 32'(bus.out_b), 32'h16);
        check("t1_id", 32'(bus.out_id), 32'd0);
        step();

        // 2: extreme operands streamed from requester 0
        bus.req_valid  = 4'b0001;
        bus.req_b[7:0] = 8'h80;
        step();
        bus.req_b[7:0] = 8'h01;
        step();
        check("t2_k_80", 32'(bus.out_k), 32'd7);
        check("t2_b_80", 32'(bus.out_b), 32'h80);
        bus.req_b[7:0] = 8'h00;
        step();
        bus.req_valid = 4'b0000;
        check("t2_k_01", 32'(bus.out_k), 32'd0);
        check("t2_zero_01", 32'(bus.out_zero), 32'd0);
        step();
        check("t2_k_00", 32'(bus.out_k), 32'd0);
        check("t2_zero_00", 32'(bus.out_zero), 32'd1);
        check("t2_valid_00", 32'(bus.out_valid), 32'd1);
        step();

        // 3: fairness with all requesters valid
        do_reset();
        bus.req_b     = {8'h55, 8'h07, 8'h3C, 8'hA0};
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i < 6) check("t3_grant", 32'(bus.req_ready), 32'd1 << (i % 4));
            if (i >= 2) begin
                check("t3_valid", 32'(bus.out_valid), 32'd1);
                check("t3_id", 32'(bus.out_id), 32'((i - 2) % 4));
            end
            step();
        end

        // 4: backpressure with a full pipeline
        do_reset();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.req_ready != '0) nacc++;
            if (i >= 2) begin
                check("t4_stall_ready", 32'(bus.req_ready), 32'd0);
                check("t4_hold_id", 32'(bus.out_id), 32'd0);
                check("t4_hold_b", 32'(bus.out_b), 32'hA0);
                check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            end
            step();
        end
        check("t4_accepted", 32'(nacc), 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t4_resume_id", 32'(bus.out_id), 32'(i));
            step();
        end
        bus.req_valid = 4'b0000;
        step();
        step();
        step();

        // 5: lone requester, pointer skip and wrap
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1 check("t5_lone", 32'(bus.req_ready), 32'b0100);
            step();
        end
        bus.req_valid = 4'b0011;
        #1 check("t5_skip0", 32'(bus.req_ready), 32'b0001);
        step();
        #1 check("t5_skip1", 32'(bus.req_ready), 32'b0010);
        step();
        bus.req_valid = 4'b1000;
        #1 check("t5_g3", 32'(bus.req_ready), 32'b1000);
        step();
        bus.req_valid = 4'b1001;
        #1 check("t5_wrap", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = 4'b0000;
        step();
        step();
        step();

        // 6: asynchronous reset mid-stream
        do_reset();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        #1 check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.out_valid), 32'd0);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        check("t6_async_ready", 32'(bus.req_ready), 32'd0);
        check("t6_async_id", 32'(bus.out_id), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1 check("t6_first_grant", 32'(bus.req_ready), 32'd1);
        step();
        check("t6_lat1", 32'(bus.out_valid), 32'd0);
        step();
        check("t6_lat2", 32'(bus.out_valid), 32'd1);
        check("t6_id", 32'(bus.out_id), 32'd0);
        bus.req_valid = 4'b0000;
        step();
        step();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
